pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush scheduler for the 5-stage pipeline (IF/ID/EX/ME/WB).
//  Merges the ID load-use pause and the ID branch redirect with multi-cycle
//  data-memory and mul/div handshakes into per-stage stall and bubble controls.
//  Tracks memory and mul/div waits in a registered FSM, with a memory-wait timeout.
// PARAMETERS
//  MEM_TIMEOUT  255  max cycles in a memory wait before forced release (1..65535)
//  TW           8    timeout counter width; MEM_TIMEOUT must be < 2**TW
// PORTS
//  clk            in   1   pipeline clock, rising edge
//  rst            in   1   asynchronous reset, active-low
//  pause_id       in   1   load-use hazard detected in ID
//  br_taken_id    in   1   branch/jump resolved taken in ID
//  mem_req        in   1   ME-stage instruction is accessing data memory
//  mem_ack        in   1   data memory completes the access this cycle
//  md_start       in   1   EX-stage instruction is a mul/div
//  md_done        in   1   mul/div unit result valid this cycle
//  stall_o        out  5   hold stage register {IF,ID,EX,ME,WB}; bit4=IF
//  bubble_o       out  5   insert NOP into stage register {IF,ID,EX,ME,WB}
//  busy_o         out  1   FSM not in RUN
//  mem_err_o      out  1   one-cycle pulse on memory-wait timeout
//  perf_stall_o   out  32  stall-cycle count (macro-dependent)
//  perf_flush_o   out  32  flush event count (macro-dependent)
// BEHAVIOUR
//  - FSM states: RUN, MEM_WAIT, MD_WAIT, MD_MEM_WAIT. Reset: RUN, timer 0, all outputs 0.
//  - stall_o/bubble_o are combinational from state + inputs (same-cycle response);
//    busy_o and mem_err_o are registered.
//  - mem_wait = (mem_req & ~mem_ack), or state in {MEM_WAIT, MD_MEM_WAIT} & ~mem_ack.
//  - md_wait = (md_start & ~md_done), or state in {MD_WAIT, MD_MEM_WAIT} & ~md_done.
//  - Priority, high to low:
//    - mem_wait: stall IF..ME, bubble WB.
//    - md_wait: stall IF..EX, bubble ME.
//    - pause_id: stall IF,ID, bubble EX.
//    - br_taken_id: bubble ID (IF/ID flush), no stall.
//  - pause_id together with br_taken_id: pause wins. ID holds, so the branch is re-evaluated next cycle.
//  - Transitions:
//    - RUN: mem_req & ~mem_ack -> MEM_WAIT (or MD_MEM_WAIT if md_wait also); else md_wait -> MD_WAIT.
//    - mem_req & mem_ack in the same cycle: stay RUN, no stall.
//    - MEM_WAIT: mem_ack -> RUN.
//    - MD_WAIT: md_done -> RUN; mem_req & ~mem_ack -> MD_MEM_WAIT.
//    - MD_MEM_WAIT: ack & done -> RUN; ack -> MD_WAIT; done -> MEM_WAIT.
//  - Ack/done cycle: stalls for that cause drop in the same cycle, so the pipeline advances on that edge.
//  - Timer:
//    - Clears on entry to any memory-wait state and increments each wait cycle.
//    - At count == MEM_TIMEOUT, treat as mem_ack: pulse mem_err_o next cycle, bubble WB, take the ack transition.
//  - rst low mid-wait: FSM immediately to RUN, timer and counters cleared, pending wait discarded.
// CONFIGURATION
//  - Macro PIPE_HAZARD_CTRL_PERF_EN defined:
//    - perf_stall_o counts cycles with any stall_o bit set.
//    - perf_flush_o counts cycles with bubble_o[3] (branch flush).
//    - Both are 32-bit, wrap at 2**32-1 -> 0, and clear on reset.
//  - Not defined: perf ports remain and are driven constant 0; no counter flops are built.
// STRUCTURE
//  - Shared header pipe_ctrl_defs.vh:
//    - state encodings ST_RUN=2'd0, ST_MEM_WAIT=2'd1, ST_MD_WAIT=2'd2, ST_MD_MEM_WAIT=2'd3;
//    - stage bit indices STG_IF=4..STG_WB=0.
//  - Sub-module mem_wait_timer (clk, rst, clr, en, expired): TW-bit counter with expiry compare.
//  - FSM, priority mux and perf counters stay in pipe_hazard_ctrl.
// TESTING
//  1 pause_id=1 for 1 cycle in RUN -> stall_o=5'b11000, bubble_o=5'b00100, state stays RUN.
//  2 br_taken_id=1, pause_id=0 -> bubble_o=5'b01000, stall_o=0.
//    Both high -> stall_o=5'b11000, bubble_o=5'b00100.
//  3 mem_req=1 with mem_ack after 3 cycles:
//    - 3 cycles of stall_o=5'b11110, bubble_o=5'b00001, busy_o=1;
//    - ack cycle stall_o=0, then RUN.
//  4 md_start with md_done at cycle 4, mem_req/no-ack raised at cycle 2, ack at cycle 6:
//    - states MD_WAIT -> MD_MEM_WAIT -> MEM_WAIT -> RUN;
//    - stall_o=5'b11110 during cycles 2-5.
//  5 MEM_TIMEOUT=4, mem_req held with no ack:
//    - after 4 wait cycles, one mem_err_o pulse and return to RUN;
//    - with PERF_EN, perf_stall_o=4.
//  6 rst driven low while in MD_MEM_WAIT:
//    - outputs 0 and state RUN asynchronously;
//    - after release with no requests, stall_o=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encodings,
// stage bit positions and the stall/bubble patterns for each hazard cause.
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] ST_RUN         = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT    = 2'd1;
  localparam logic [1:0] ST_MD_WAIT     = 2'd2;
  localparam logic [1:0] ST_MD_MEM_WAIT = 2'd3;

  localparam int STG_IF = 4;
  localparam int STG_ID = 3;
  localparam int STG_EX = 2;
  localparam int STG_ME = 1;
  localparam int STG_WB = 0;

  typedef struct packed {
    logic [4:0] stall;
    logic [4:0] bubble;
  } ctrl_t;

  // Each cause holds every stage upstream of the hazard and drains a NOP into the next one.
  localparam logic [4:0] STALL_MEM   = (5'b1 << STG_IF) | (5'b1 << STG_ID) | (5'b1 << STG_EX) | (5'b1 << STG_ME);
  localparam logic [4:0] STALL_MD    = (5'b1 << STG_IF) | (5'b1 << STG_ID) | (5'b1 << STG_EX);
  localparam logic [4:0] STALL_PAUSE = (5'b1 << STG_IF) | (5'b1 << STG_ID);

  localparam ctrl_t CTRL_MEM   = '{stall: STALL_MEM,   bubble: 5'b1 << STG_WB};
  localparam ctrl_t CTRL_MD    = '{stall: STALL_MD,    bubble: 5'b1 << STG_ME};
  localparam ctrl_t CTRL_PAUSE = '{stall: STALL_PAUSE, bubble: 5'b1 << STG_EX};
  localparam ctrl_t CTRL_FLUSH = '{stall: 5'b0,        bubble: 5'b1 << STG_ID};

endpackage

// File: rtl/pipe_hazard_ctrl_mem_wait_timer.sv
// Memory-wait timeout counter: clr restarts the count (counting the current
// cycle when en is also high), en advances it, expired flags the limit.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int          TW          = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= en ? TW'(1) : '0;
    end else if (en) begin
      cnt <= cnt + TW'(1);
    end
  end

  assign expired = (cnt == TW'(MEM_TIMEOUT));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush scheduler with memory and mul/div wait FSM.
// Optional performance counters are built when PIPE_HAZARD_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int          TW          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pause_id,
  input  logic        br_taken_id,
  input  logic        mem_req,
  input  logic        mem_ack,
  input  logic        md_start,
  input  logic        md_done,
  output logic [4:0]  stall_o,
  output logic [4:0]  bubble_o,
  output logic        busy_o,
  output logic        mem_err_o,
  output logic [31:0] perf_stall_o,
  output logic [31:0] perf_flush_o
);

  logic [1:0] state, state_nxt;
  logic       in_mem, in_md, expired, timeout_hit, ack_eff;
  logic       mem_new, mem_wait, md_wait, timer_clr;
  ctrl_t      ctrl;

  assign in_mem = (state == ST_MEM_WAIT) || (state == ST_MD_MEM_WAIT);
  assign in_md  = (state == ST_MD_WAIT)  || (state == ST_MD_MEM_WAIT);

  // A genuine ack on the limit cycle is a normal completion, not a timeout.
  assign timeout_hit = in_mem & expired & ~mem_ack;
  assign ack_eff     = mem_ack | timeout_hit;

  assign mem_new  = mem_req & ~mem_ack;
  assign mem_wait = in_mem ? ~ack_eff : mem_new;
  assign md_wait  = in_md ? ~md_done : (md_start & ~md_done);

  always_comb begin
    ctrl = '0;
    if (mem_wait)         ctrl = CTRL_MEM;
    else if (md_wait)     ctrl = CTRL_MD;
    else if (pause_id)    ctrl = CTRL_PAUSE;
    else if (br_taken_id) ctrl = CTRL_FLUSH;
    if (timeout_hit) ctrl.bubble[STG_WB] = 1'b1;
  end

  assign stall_o  = rst ? ctrl.stall  : 5'b0;
  assign bubble_o = rst ? ctrl.bubble : 5'b0;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:         state_nxt = {md_wait, mem_wait};
      ST_MEM_WAIT:    state_nxt = mem_wait ? ST_MEM_WAIT : ST_RUN;
      ST_MD_WAIT:     state_nxt = {md_wait, mem_wait};
      ST_MD_MEM_WAIT: state_nxt = {md_wait, mem_wait};
      default:        state_nxt = ST_RUN;
    endcase
  end

  assign timer_clr = ~in_mem & ((state_nxt == ST_MEM_WAIT) || (state_nxt == ST_MD_MEM_WAIT));

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TW         (TW)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr),
    .en     (mem_wait),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RUN;
      busy_o    <= 1'b0;
      mem_err_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy_o    <= (state_nxt != ST_RUN);
      mem_err_o <= timeout_hit;
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (|stall_o)         perf_stall_q <= perf_stall_q + 32'd1;
      if (bubble_o[STG_ID]) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_o = perf_stall_q;
  assign perf_flush_o = perf_flush_q;
`else
  assign perf_stall_o = 32'd0;
  assign perf_flush_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl built with a 4-cycle memory timeout.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        pause_id, br_taken_id, mem_req, mem_ack, md_start, md_done;
  logic [4:0]  stall_o, bubble_o;
  logic        busy_o, mem_err_o;
  logic [31:0] perf_stall_o, perf_flush_o;

  int total = 0;
  int bad   = 0;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT(4),
    .TW         (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pause_id    (pause_id),
    .br_taken_id (br_taken_id),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .md_start    (md_start),
    .md_done     (md_done),
    .stall_o     (stall_o),
    .bubble_o    (bubble_o),
    .busy_o      (busy_o),
    .mem_err_o   (mem_err_o),
    .perf_stall_o(perf_stall_o),
    .perf_flush_o(perf_flush_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    pause_id = 0; br_taken_id = 0; mem_req = 0; mem_ack = 0; md_start = 0; md_done = 0;
    #3;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_bubble", 32'(bubble_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_err", 32'(mem_err_o), 32'd0);
    chk("rst_perf_stall", perf_stall_o, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // load-use pause
    tick(); pause_id = 1; #1;
    chk("pause_stall", 32'(stall_o), 32'(5'b11000));
    chk("pause_bubble", 32'(bubble_o), 32'(5'b00100));
    tick(); pause_id = 0; #1;
    chk("pause_busy", 32'(busy_o), 32'd0);
    chk("pause_after_stall", 32'(stall_o), 32'd0);

    // branch flush, then branch together with pause
    tick(); br_taken_id = 1; #1;
    chk("br_bubble", 32'(bubble_o), 32'(5'b01000));
    chk("br_stall", 32'(stall_o), 32'd0);
    tick(); pause_id = 1; #1;
    chk("brpause_stall", 32'(stall_o), 32'(5'b11000));
    chk("brpause_bubble", 32'(bubble_o), 32'(5'b00100));
    tick(); pause_id = 0; br_taken_id = 0; #1;

    // memory wait acked after 3 cycles
    tick(); mem_req = 1; #1;
    chk("mem_c0_stall", 32'(stall_o), 32'(5'b11110));
    chk("mem_c0_bubble", 32'(bubble_o), 32'(5'b00001));
    tick(); #1;
    chk("mem_c1_stall", 32'(stall_o), 32'(5'b11110));
    chk("mem_c1_busy", 32'(busy_o), 32'd1);
    tick(); #1;
    chk("mem_c2_stall", 32'(stall_o), 32'(5'b11110));
    tick(); mem_ack = 1; #1;
    chk("mem_ack_stall", 32'(stall_o), 32'd0);
    chk("mem_ack_busy", 32'(busy_o), 32'd1);
    tick(); mem_req = 0; mem_ack = 0; #1;
    chk("mem_done_busy", 32'(busy_o), 32'd0);
    chk("mem_done_stall", 32'(stall_o), 32'd0);

    // mul/div wait overlapped by a memory wait
    tick(); md_start = 1; #1;
    chk("md_c0_stall", 32'(stall_o), 32'(5'b11100));
    chk("md_c0_bubble", 32'(bubble_o), 32'(5'b00010));
    tick(); md_start = 0; #1;
    chk("md_c1_stall", 32'(stall_o), 32'(5'b11100));
    chk("md_c1_busy", 32'(busy_o), 32'd1);
    tick(); mem_req = 1; #1;
    chk("md_c2_stall", 32'(stall_o), 32'(5'b11110));
    tick(); #1;
    chk("md_c3_stall", 32'(stall_o), 32'(5'b11110));
    tick(); md_done = 1; #1;
    chk("md_c4_stall", 32'(stall_o), 32'(5'b11110));
    tick(); md_done = 0; #1;
    chk("md_c5_stall", 32'(stall_o), 32'(5'b11110));
    tick(); mem_ack = 1; #1;
    chk("md_c6_stall", 32'(stall_o), 32'd0);
    tick(); mem_req = 0; mem_ack = 0; #1;
    chk("md_c7_busy", 32'(busy_o), 32'd0);
    chk("md_c7_stall", 32'(stall_o), 32'd0);
    chk("perf_stall_acc", perf_stall_o, PERF ? 32'd11 : 32'd0);
    chk("perf_flush_acc", perf_flush_o, PERF ? 32'd1 : 32'd0);

    // memory timeout after 4 wait cycles, from a fresh reset
    tick(); rst = 0; #1;
    chk("rst2_perf_stall", perf_stall_o, 32'd0);
    rst = 1;
    tick(); mem_req = 1; #1;
    chk("to_c0_stall", 32'(stall_o), 32'(5'b11110));
    tick(); #1;
    tick(); #1;
    tick(); #1;
    chk("to_c3_stall", 32'(stall_o), 32'(5'b11110));
    chk("to_c3_busy", 32'(busy_o), 32'd1);
    tick(); #1;
    chk("to_c4_stall", 32'(stall_o), 32'd0);
    chk("to_c4_bubble", 32'(bubble_o), 32'(5'b00001));
    chk("to_c4_err", 32'(mem_err_o), 32'd0);
    tick(); mem_req = 0; #1;
    chk("to_c5_err", 32'(mem_err_o), 32'd1);
    chk("to_c5_busy", 32'(busy_o), 32'd0);
    chk("to_perf_stall", perf_stall_o, PERF ? 32'd4 : 32'd0);
    chk("to_perf_flush", perf_flush_o, 32'd0);
    tick(); #1;
    chk("to_c6_err", 32'(mem_err_o), 32'd0);

    // asynchronous reset while in MD_MEM_WAIT
    tick(); md_start = 1; mem_req = 1; #1;
    chk("ar_c0_stall", 32'(stall_o), 32'(5'b11110));
    tick(); md_start = 0; #1;
    chk("ar_c1_busy", 32'(busy_o), 32'd1);
    #1 rst = 0;
    #1;
    chk("ar_stall", 32'(stall_o), 32'd0);
    chk("ar_bubble", 32'(bubble_o), 32'd0);
    chk("ar_busy", 32'(busy_o), 32'd0);
    chk("ar_perf", perf_stall_o, 32'd0);
    mem_req = 0;
    tick(); rst = 1; #1;
    tick(); #1;
    chk("ar_post_stall", 32'(stall_o), 32'd0);
    chk("ar_post_busy", 32'(busy_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
